// File: rtl/pbkdf2_dispatch.sv
// Fans PBKDF2 jobs out to NUM_CORES_P hmac cores round-robin and retires results
// in request order through an order queue; zero-iteration jobs bypass the cores.
module pbkdf2_dispatch #(
    parameter int NUM_CORES_P   = 4,
    parameter int ORDER_DEPTH_P = 8,
    parameter int PASS_W_P      = 512,
    parameter int SALT_W_P      = 512,
    parameter int HASH_W_P      = 256,
    parameter int ID_W_P        = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [5:0]                      salt_len_i,
    input  logic [31:0]                     iters_i,
    input  logic [PASS_W_P-1:0]             pass_i,
    input  logic [SALT_W_P-1:0]             salt_i,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [HASH_W_P-1:0]             hash_o,
    output logic [ID_W_P-1:0]               id_o,
    output logic                            err_o,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_CORES_P-1:0]          core_v_o,
    output logic [5:0]                      core_salt_len_o,
    output logic [31:0]                     core_iters_o,
    output logic [PASS_W_P-1:0]             core_pass_o,
    output logic [SALT_W_P-1:0]             core_salt_o,
    input  logic [NUM_CORES_P-1:0]          core_ready_i,
    input  logic [NUM_CORES_P-1:0]          core_v_i,
    input  logic [NUM_CORES_P*HASH_W_P-1:0] core_hash_i,
    output logic [NUM_CORES_P-1:0]          core_yumi_o
);

    localparam int CORE_W = (NUM_CORES_P > 1) ? $clog2(NUM_CORES_P) : 1;
    localparam int IDX_W  = CORE_W + 1;
    localparam int PTR_W  = $clog2(ORDER_DEPTH_P);

    typedef struct packed {
        logic              bypass;
        logic [CORE_W-1:0] core;
    } entry_t;

    entry_t              ord_q [ORDER_DEPTH_P];
    logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [CORE_W-1:0]   rr_q, rr_d;
    logic [ID_W_P-1:0]   ret_q, ret_d;

    logic [CORE_W-1:0]   grant;
    logic                grant_vld;
    logic [IDX_W-1:0]    idx_w;
    logic                q_full, q_empty, accept, issue, pop;
    entry_t              head;

    // First ready core at or after rr, wrapping at NUM_CORES_P.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx_w     = '0;
        for (int i = 0; i < NUM_CORES_P; i++) begin
            idx_w = {1'b0, rr_q} + IDX_W'(i);
            if (idx_w >= IDX_W'(NUM_CORES_P)) idx_w = idx_w - IDX_W'(NUM_CORES_P);
            if (!grant_vld && core_ready_i[idx_w[CORE_W-1:0]]) begin
                grant_vld = 1'b1;
                grant     = idx_w[CORE_W-1:0];
            end
        end
    end

    assign q_full   = (count_q == (PTR_W+1)'(ORDER_DEPTH_P));
    assign q_empty  = (count_q == '0);
    assign in_ready = !rst_i && !q_full && grant_vld;
    assign accept   = in_valid && in_ready;
    assign issue    = accept && (iters_i != 32'd0);

    assign core_salt_len_o = salt_len_i;
    assign core_iters_o    = iters_i;
    assign core_pass_o     = pass_i;
    assign core_salt_o     = salt_i;

    assign head      = ord_q[rd_q];
    assign out_valid = !rst_i && !q_empty && (head.bypass || core_v_i[head.core]);
    assign err_o     = !rst_i && !q_empty && head.bypass;
    assign hash_o    = (!rst_i && !q_empty && !head.bypass)
                       ? core_hash_i[int'(head.core) * HASH_W_P +: HASH_W_P] : '0;
    assign id_o      = rst_i ? '0 : ret_q;
    assign pop       = out_valid && out_ready;

    always_comb begin
        core_v_o    = '0;
        core_yumi_o = '0;
        if (issue) core_v_o[grant] = 1'b1;
        if (pop && !head.bypass) core_yumi_o[head.core] = 1'b1;
    end

    always_comb begin
        wr_d    = accept ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        ret_d   = pop ? ret_q + 1'b1 : ret_q;
        rr_d    = rr_q;
        if (issue) rr_d = (grant == CORE_W'(NUM_CORES_P - 1)) ? '0 : grant + 1'b1;
        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            rr_q    <= '0;
            ret_q   <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            rr_q    <= rr_d;
            ret_q   <= ret_d;
        end
    end

    // Entry payload needs no reset: it is only read while count_q says it is live.
    always_ff @(posedge clk_i) begin
        if (accept) ord_q[wr_q] <= '{bypass: !issue, core: grant};
    end

endmodule

// File: tb/tb_pbkdf2_dispatch.sv
// Bench for pbkdf2_dispatch: behavioural core models, an order-queue scoreboard,
// a vector table and directed multi-cycle sequences.
module tb_pbkdf2_dispatch;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int HW = 256;
    localparam logic [255:0] REF_HASH =
        256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
    localparam logic [63:0] PW_STR   = 64'h70617373776f7264;
    localparam logic [63:0] SALT_STR = 64'h0000000073616c74;

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    logic [5:0] salt_len_i = '0;
    logic [31:0] iters_i = '0;
    logic [63:0] pass_i = '0, salt_i = '0;
    logic in_valid = 1'b0, in_ready;
    logic [HW-1:0] hash_o;
    logic [3:0] id_o;
    logic err_o, out_valid;
    logic out_ready = 1'b1;
    logic [N-1:0] core_v_o, core_ready_i, core_v_i, core_yumi_o;
    logic [5:0] core_salt_len_o;
    logic [31:0] core_iters_o;
    logic [63:0] core_pass_o, core_salt_o;
    logic [N*HW-1:0] core_hash_i;

    int n_checks = 0;
    int n_fail = 0;

    pbkdf2_dispatch #(.NUM_CORES_P(N), .ORDER_DEPTH_P(D), .PASS_W_P(64), .SALT_W_P(64),
                      .HASH_W_P(HW), .ID_W_P(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .salt_len_i(salt_len_i), .iters_i(iters_i),
        .pass_i(pass_i), .salt_i(salt_i), .in_valid(in_valid), .in_ready(in_ready),
        .hash_o(hash_o), .id_o(id_o), .err_o(err_o), .out_valid(out_valid),
        .out_ready(out_ready), .core_v_o(core_v_o), .core_salt_len_o(core_salt_len_o),
        .core_iters_o(core_iters_o), .core_pass_o(core_pass_o), .core_salt_o(core_salt_o),
        .core_ready_i(core_ready_i), .core_v_i(core_v_i), .core_hash_i(core_hash_i),
        .core_yumi_o(core_yumi_o));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // What a core returns: the real PBKDF2 vector for the known input, otherwise a tagged mix.
    function automatic logic [255:0] job_hash(input logic [63:0] pw, input logic [63:0] sl,
                                              input logic [5:0] ln, input logic [31:0] it);
        if (pw == PW_STR && sl == SALT_STR && ln == 6'd4 && it == 32'd1) return REF_HASH;
        return {pw, sl, it, 26'd0, ln, pw ^ sl ^ 64'hc3a5_5a3c_0ff0_9669};
    endfunction

    // Core models: busy from issue until yumi, result after a latency tied to iters.
    logic [N-1:0] c_busy = '0, spur = '0;
    int c_cnt [N];
    logic [255:0] c_res [N];
    logic jit = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst_i) c_busy[k] <= 1'b0;
            else if (core_yumi_o[k]) c_busy[k] <= 1'b0;
            else if (core_v_o[k]) begin
                c_busy[k] <= 1'b1;
                c_cnt[k]  <= ((core_iters_o > 32'd60) ? 60 : int'(core_iters_o))
                             + (jit ? int'($urandom_range(0, 3)) : 0);
                c_res[k]  <= job_hash(core_pass_o, core_salt_o, core_salt_len_o, core_iters_o);
            end else if (c_busy[k] && c_cnt[k] != 0) c_cnt[k] <= c_cnt[k] - 1;
        end
    end

    always_comb begin
        core_ready_i = ~c_busy;
        core_v_i     = spur;
        core_hash_i  = '0;
        for (int k = 0; k < N; k++) begin
            if (c_busy[k] && c_cnt[k] == 0) core_v_i[k] = 1'b1;
            core_hash_i[k*HW +: HW] = c_res[k];
        end
    end

    // Reference model: FIFO of outstanding jobs in request order.
    typedef struct { logic byp; int core; logic [255:0] h; } job_t;
    typedef struct { logic [3:0] id; logic err; logic [255:0] h; } rec_t;
    job_t mq[$];
    rec_t rec[$];
    int m_rr = 0;
    logic [3:0] m_id = '0;

    always @(negedge clk) begin
        logic [N-1:0] exp_cv, exp_yumi;
        logic acc, pop, exp_ov;
        int g;
        if (rst_i) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_err", err_o, 0);
            chk("rst_core_v", core_v_o, 0);
            chk("rst_yumi", core_yumi_o, 0);
            chk("rst_hash", hash_o, 0);
            chk("rst_id", id_o, 0);
            mq.delete();
            m_rr = 0;
            m_id = '0;
        end else begin
            chk("in_ready", in_ready, (mq.size() < D) && (core_ready_i != 0));
            acc = in_valid && in_ready;
            exp_cv = '0;
            g = -1;
            if (acc && iters_i != 0) begin
                for (int i = 0; i < N; i++)
                    if (g < 0 && core_ready_i[(m_rr + i) % N]) g = (m_rr + i) % N;
                if (g >= 0) exp_cv[g] = 1'b1;
            end
            chk("core_v", core_v_o, exp_cv);
            if (exp_cv != 0) chk("bcast_pass", core_pass_o, pass_i);
            exp_yumi = '0;
            pop = 1'b0;
            if (mq.size() == 0) begin
                chk("empty_out_valid", out_valid, 0);
            end else begin
                exp_ov = mq[0].byp ? 1'b1 : core_v_i[mq[0].core];
                chk("out_valid", out_valid, exp_ov);
                if (out_valid) begin
                    chk("hash", hash_o, mq[0].h);
                    chk("err", err_o, mq[0].byp);
                    chk("id", id_o, m_id);
                end
                pop = out_valid && out_ready;
                if (pop && !mq[0].byp) exp_yumi[mq[0].core] = 1'b1;
            end
            chk("yumi", core_yumi_o, exp_yumi);
            if (pop) begin
                rec.push_back('{id_o, err_o, hash_o});
                void'(mq.pop_front());
                m_id = m_id + 1'b1;
            end
            if (acc) begin
                if (iters_i == 0) mq.push_back('{1'b1, 0, 256'd0});
                else begin
                    mq.push_back('{1'b0, g, job_hash(pass_i, salt_i, salt_len_i, iters_i)});
                    m_rr = (g + 1) % N;
                end
            end
        end
    end

    // All driver tasks are entered and left just after a rising edge.
    task automatic send(input logic [31:0] it, input logic [63:0] pw, input logic [63:0] sl,
                        input logic [5:0] ln, output logic [N-1:0] cv);
        int k;
        cv = '0;
        in_valid = 1'b1; iters_i = it; pass_i = pw; salt_i = sl; salt_len_i = ln;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk); #1;
        end
        if (k == 300) chk("send_timeout", 1, 0);
        else cv = core_v_o;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (mq.size() == 0) break;
        end
        if (k == 1000) chk("drain_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
    endtask

    typedef struct packed {
        logic rst; logic [31:0] iters; logic [N-1:0] exp_cv; logic [3:0] exp_id; logic exp_err;
    } vec_t;
    vec_t tbl [9];

    initial begin
        logic [N-1:0] cv;
        logic [255:0] cap_h;
        logic [3:0] cap_id;
        logic cap_err;
        int k;

        tbl[0] = '{1'b1, 32'd3, 4'b0001, 4'd0, 1'b0};
        tbl[1] = '{1'b0, 32'd3, 4'b0010, 4'd1, 1'b0};
        tbl[2] = '{1'b0, 32'd3, 4'b0100, 4'd2, 1'b0};
        tbl[3] = '{1'b0, 32'd3, 4'b1000, 4'd3, 1'b0};
        tbl[4] = '{1'b0, 32'd3, 4'b0001, 4'd4, 1'b0};
        tbl[5] = '{1'b0, 32'd3, 4'b0010, 4'd5, 1'b0};
        tbl[6] = '{1'b1, 32'd5, 4'b0001, 4'd0, 1'b0};
        tbl[7] = '{1'b0, 32'd0, 4'b0000, 4'd1, 1'b1};
        tbl[8] = '{1'b0, 32'd5, 4'b0010, 4'd2, 1'b0};

        @(posedge clk); #1;
        do_reset();

        // Known PBKDF2 vector through core 0.
        rec.delete();
        send(32'd1, PW_STR, SALT_STR, 6'd4, cv);
        chk("single_cv", cv, 4'b0001);
        drain();
        chk("single_count", rec.size(), 1);
        if (rec.size() > 0) begin
            chk("single_hash", rec[0].h, REF_HASH);
            chk("single_id", rec[0].id, 0);
            chk("single_err", rec[0].err, 0);
        end

        // Round-robin and bypass vectors.
        rec.delete();
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].rst) begin
                drain();
                do_reset();
            end
            send(tbl[i].iters, {$urandom, $urandom}, {$urandom, $urandom}, 6'(i), cv);
            chk($sformatf("tbl%0d_cv", i), cv, tbl[i].exp_cv);
        end
        drain();
        chk("tbl_count", rec.size(), 9);
        for (int i = 0; i < 9 && i < rec.size(); i++) begin
            chk($sformatf("tbl%0d_id", i), rec[i].id, tbl[i].exp_id);
            chk($sformatf("tbl%0d_err", i), rec[i].err, tbl[i].exp_err);
        end

        // Reorder: core 1 finishes first but must wait behind core 0.
        do_reset();
        rec.delete();
        send(32'd4096, 64'h1111, 64'h2222, 6'd8, cv);
        chk("reord_cv0", cv, 4'b0001);
        send(32'd1, 64'h3333, 64'h4444, 6'd8, cv);
        chk("reord_cv1", cv, 4'b0010);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (core_v_i[1] && !core_v_i[0]) break;
        end
        chk("reord_wait", k < 100, 1);
        chk("reord_yumi1", core_yumi_o[1], 0);
        chk("reord_ov", out_valid, 0);
        @(posedge clk); #1;
        drain();
        chk("reord_count", rec.size(), 2);
        if (rec.size() == 2) begin
            chk("reord_id0", rec[0].id, 0);
            chk("reord_id1", rec[1].id, 1);
        end

        // Full queue with cores still ready, stall stability, no pass-through.
        do_reset();
        out_ready = 1'b0;
        send(32'd1, 64'h5555, 64'h6666, 6'd3, cv);
        for (int i = 0; i < 3; i++) send(32'd0, 64'h0, 64'h0, 6'd0, cv);
        in_valid = 1'b1; iters_i = 32'd0;
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_cores_ready", core_ready_i != 0, 1);
        cap_h = hash_o; cap_id = id_o; cap_err = err_o;
        chk("full_head_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_hash", hash_o, cap_h);
            chk("stall_id", id_o, cap_id);
            chk("stall_err", err_o, cap_err);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_no_passthru", in_ready, 0);
        @(negedge clk);
        chk("full_after_pop", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Spurious core valid with empty queue is ignored.
        spur = 4'hF;
        @(negedge clk);
        chk("spur_ov", out_valid, 0);
        chk("spur_yumi", core_yumi_o, 0);
        @(posedge clk); #1;
        spur = '0;

        // Reset mid-run drops queued entries; IDs restart at 0.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'd2, {$urandom, $urandom}, 64'h7, 6'd1, cv);
        repeat (4) @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("post_rst_ov", out_valid, 0);
        chk("post_rst_id", id_o, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        rec.delete();
        send(32'd2, 64'h99, 64'h88, 6'd2, cv);
        drain();
        chk("post_rst_first_id", (rec.size() > 0) ? rec[0].id : 4'hF, 0);

        // ID wrap at 2^4.
        do_reset();
        rec.delete();
        for (int i = 0; i < 17; i++) send(32'd0, 64'h0, 64'h0, 6'd0, cv);
        drain();
        chk("wrap_count", rec.size(), 17);
        if (rec.size() == 17) begin
            chk("wrap_id16", rec[15].id, 15);
            chk("wrap_id17", rec[16].id, 0);
        end

        // Random traffic checked by the scoreboard.
        do_reset();
        jit = 1'b1;
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            iters_i    = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
            pass_i     = {$urandom, $urandom};
            salt_i     = {$urandom, $urandom};
            salt_len_i = 6'($urandom_range(0, 63));
            out_ready  = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pbkdf2_dispatch.md
# pbkdf2_dispatch

Parametrised job dispatcher that fans PBKDF2-HMAC-SHA256 requests out to `NUM_CORES_P` `hmac_sha256` cores and returns results in strict request order. It sits between the trace/host request stream and the core array. It generalises the single-core hookup to N cores with round-robin issue, an order queue for in-order retirement, a zero-iteration bypass, and per-job sequence IDs.

## Interface
Parameters:
- `NUM_CORES_P`, default 4: number of attached cores; allowed range 1..16.
- `ORDER_DEPTH_P`, default 8: order-queue entries; must be a power of two, at least 2.
- `PASS_W_P`, default 512: password width.
- `SALT_W_P`, default 512: salt width.
- `HASH_W_P`, default 256: result width.
- `ID_W_P`, default 16: sequence-ID width.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset; synchronous, active-high.
- `salt_len_i` in 6: salt length in bytes.
- `iters_i` in 32: iteration count.
- `pass_i` in `PASS_W_P`: password.
- `salt_i` in `SALT_W_P`: salt.
- `in_valid` in 1: a request is presented.
- `in_ready` out 1: the dispatcher can accept a request.
- `hash_o` out `HASH_W_P`: result hash.
- `id_o` out `ID_W_P`: sequence ID of the result.
- `err_o` out 1: result came from a zero-iteration job.
- `out_valid` out 1: a result is presented.
- `out_ready` in 1: the consumer takes the result.
- `core_v_o` out `NUM_CORES_P`: one-hot issue strobe.
- `core_salt_len_o`, `core_iters_o`, `core_pass_o`, `core_salt_o` out: shared broadcast of the request fields.
- `core_ready_i` in `NUM_CORES_P`: per-core ready.
- `core_v_i` in `NUM_CORES_P`: per-core result valid.
- `core_hash_i` in `NUM_CORES_P*HASH_W_P`: per-core hashes; core k occupies slice [k*HASH_W_P +: HASH_W_P].
- `core_yumi_o` out `NUM_CORES_P`: per-core result acknowledge.

## Operation
- Core contract: a core keeps `core_ready_i` low from acceptance until its result is yumi'd. So each core has at most one job outstanding.
- Issue arbitration: round-robin pointer `rr`. Grant goes to the first core with `core_ready_i`=1, scanning from `rr` upward with wrap. On each accepted request, `rr` becomes grant+1, wrapping at `NUM_CORES_P`.
- `in_ready` = !rst_i & !q_full & |core_ready_i. It does not depend on request data.
- Accept means `in_valid & in_ready`.
- On accept with `iters_i`≠0:
  - `core_v_o[grant]`=1 in the same cycle; the request fields are driven straight through to the broadcast buses.
  - The queue entry {bypass=0, core=grant} is pushed.
- On accept with `iters_i`=0:
  - No core strobe is issued and `rr` is unchanged.
  - The queue entry {bypass=1} is pushed.
- Retirement reads the queue head only:
  - Bypass entry: `out_valid`=1, `hash_o`=0, `err_o`=1.
  - Core entry c: `out_valid`=`core_v_i[c]`, `hash_o`=slice c, `err_o`=0.
- Pop means `out_valid & out_ready`. On pop, `core_yumi_o[c]`=1 only when the head is a core entry; the retire counter increments.
- `id_o` = retire counter, which wraps modulo 2^`ID_W_P`. The first result after reset carries ID 0.
- Results from non-head cores are held by those cores until their entry reaches the head. Completion order never reorders output.

## Timing
- Issue latency: 0 cycles, purely combinational from accept to `core_v_o`.
- Bypass latency: a zero-iteration job accepted in cycle t can retire in cycle t+1 at the earliest, once it is at the head.
- Core result latency: a result with `core_v_i` high in cycle t can pop in cycle t, if its entry is at the head.
- Queue:
  - Full at `ORDER_DEPTH_P` entries.
  - Push and pop in the same cycle both take effect, so the count is unchanged.
  - A full queue blocks accept even when a pop is happening in the same cycle; there is no pass-through.
- Empty queue: `out_valid`=0 and `core_yumi_o`=0, whatever `core_v_i` is.
- Reset, in the cycle `rst_i` is high and on the following edge:
  - The queue empties, `rr`=0 and the retire counter is 0.
  - `in_ready`, `out_valid`, `err_o`, `core_v_o` and `core_yumi_o` are all 0.
  - `hash_o` and `id_o` read 0.
- Reset mid-operation drops all queued entries. The cores are reset by the same `rst_i`.
- `core_v_i` asserted for a core with no queue entry is ignored; the dispatcher never acks it.
- Stalled output (`out_valid`=1, `out_ready`=0): the head holds and `hash_o`/`id_o`/`err_o` stay stable. Issue continues until the queue is full or no core is ready.

## Test plan
- Single job: `NUM_CORES_P`=4 with a known PBKDF2 vector (pass "password", salt "salt", iters=1) -> `core_v_o`=0001, then one result with `id_o`=0 and `err_o`=0 matching the reference hash.
- Round-robin: all cores ready, 6 back-to-back jobs -> `core_v_o` sequence 0001, 0010, 0100, 1000, then the next two jobs go to the first cores made ready again in rr order; `id_o` runs 0..5.
- Reorder: a job to core 0 with iters=4096 and a job to core 1 with iters=1 -> core 1 finishes first but `core_yumi_o[1]` stays low until core 0's result pops; output IDs are 0 then 1.
- Bypass: iters=0 between two normal jobs -> the middle result has `hash_o`=0, `err_o`=1 and `id_o`=1, with no `core_v_o` pulse.
- Backpressure/full: `ORDER_DEPTH_P`=2 and `out_ready`=0 -> `in_ready` drops after 2 accepts while cores are still ready; hash and ID stay stable across 10 stalled cycles.
- Reset and wrap: assert `rst_i` mid-run -> all outputs are 0 the next cycle and the first post-reset `id_o` is 0. Separately, with `ID_W_P`=4, 17 jobs -> the 17th `id_o` is 0.
